// File: rtl/qpi_responder_if.sv
// qpi_responder_if: pad-side QPI pins and decoder-side byte stream for qpi_responder.
// slave = the responder itself, master = host pads plus command decoder.
`timescale 1ns/1ps
interface qpi_responder_if;
    logic       qpi_csb;
    logic       qpi_clk;
    logic [3:0] qpi_io_di;
    logic [3:0] qpi_io_do;
    logic       qpi_io_oe;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       rx_end;
    logic       rd_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       qpi_err;

    modport slave (
        input  qpi_csb, qpi_clk, qpi_io_di, rd_req, tx_data, tx_valid,
        output qpi_io_do, qpi_io_oe, rx_valid, rx_data, rx_first, rx_end,
               tx_ready, qpi_err
    );

    modport master (
        output qpi_csb, qpi_clk, qpi_io_di, rd_req, tx_data, tx_valid,
        input  qpi_io_do, qpi_io_oe, rx_valid, rx_data, rx_first, rx_end,
               tx_ready, qpi_err
    );
endinterface

// File: rtl/qpi_responder.sv
// qpi_responder: device-side QPI link layer. Oversamples the host pins in the
// clock domain, deserialises nibble pairs into bytes and serialises response
// bytes after a one-byte turnaround.
// Optional protocol error detection: define QPI_RESPONDER_ERR_EN.
`timescale 1ns/1ps
module qpi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic           clock,
    input  logic           reset,
    qpi_responder_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TURN,
        ST_TX,
        ST_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [3:0]             di_sync [SYNC_STAGES];

    // One extra stage after the synchronisers: *_r is the detection stage,
    // *_rr its previous value.
    logic       csb_r, csb_rr;
    logic       clk_r, clk_rr;
    logic [3:0] di_r;

    logic       framing;
    logic       csb_fall, csb_rise;
    logic       fall_e, rise_e;
    logic       hi_take, byte_done;
    logic       rx_take, tx_load, tx_low;
    logic [7:0] tx_sel;

    logic       hi_phase;
    logic       first_pend;
    logic [3:0] hi_nib;
    logic [3:0] tx_low_nib;

    logic       rx_valid_q, rx_first_q, rx_end_q, tx_ready_q, oe_q;
    logic [7:0] rx_data_q;
    logic [3:0] do_q;

    // Pin synchronisers; deliberately not reset so they keep tracking the pins
    // and no false edge appears when reset is released.
    always_ff @(posedge clock) begin
        csb_sync   <= {csb_sync[SYNC_STAGES-2:0], bus.qpi_csb};
        clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.qpi_clk};
        di_sync[0] <= bus.qpi_io_di;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            di_sync[i] <= di_sync[i-1];
        end
        csb_r  <= csb_sync[SYNC_STAGES-1];
        csb_rr <= csb_r;
        clk_r  <= clk_sync[SYNC_STAGES-1];
        clk_rr <= clk_r;
        di_r   <= di_sync[SYNC_STAGES-1];
    end

    // Edge and byte strobes; a csb rise forces csb_r high, which masks any clk edge.
    always_comb begin
        framing   = (state == ST_RX) || (state == ST_TURN) || (state == ST_TX);
        csb_fall  = csb_rr & ~csb_r;
        csb_rise  = ~csb_rr & csb_r;
        fall_e    = framing & ~csb_r & clk_rr & ~clk_r;
        rise_e    = framing & ~csb_r & ~clk_rr & clk_r;
        hi_take   = fall_e & hi_phase;
        byte_done = rise_e & ~hi_phase;
        rx_take   = byte_done & (state == ST_RX);
        tx_load   = hi_take & (state == ST_TX);
        tx_low    = byte_done & (state == ST_TX);
        tx_sel    = bus.tx_valid ? bus.tx_data : IDLE_BYTE;
    end

    // State register; a reset inside a live transaction parks in HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= csb_r ? ST_IDLE : ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; rd_req is looked at in the rx_valid cycle so a decoder
    // reacting to the command byte combinationally still gets its turnaround.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (csb_fall) state_nxt = ST_RX;
            ST_RX: begin
                if (csb_rise)                       state_nxt = ST_IDLE;
                else if (rx_valid_q && bus.rd_req)  state_nxt = ST_TURN;
            end
            ST_TURN: begin
                if (csb_rise)       state_nxt = ST_IDLE;
                else if (byte_done) state_nxt = ST_TX;
            end
            ST_TX:   if (csb_rise) state_nxt = ST_IDLE;
            ST_HOLD: if (csb_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Nibble framing, receive byte assembly and transmit serialisation.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_phase   <= 1'b1;
            first_pend <= 1'b0;
            hi_nib     <= '0;
            tx_low_nib <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            rx_end_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= '0;
            do_q       <= '0;
            oe_q       <= 1'b0;
        end else begin
            rx_valid_q <= rx_take;
            rx_first_q <= rx_take & first_pend;
            rx_end_q   <= csb_rise & framing;
            tx_ready_q <= tx_load & bus.tx_valid;
            if (csb_fall) begin
                hi_phase   <= 1'b1;
                first_pend <= 1'b1;
            end
            if (hi_take) begin
                hi_nib   <= di_r;
                hi_phase <= 1'b0;
            end
            if (byte_done) begin
                hi_phase <= 1'b1;
            end
            if (rx_take) begin
                rx_data_q  <= {hi_nib, di_r};
                first_pend <= 1'b0;
            end
            if (tx_load) begin
                tx_low_nib <= tx_sel[3:0];
                do_q       <= tx_sel[7:4];
                oe_q       <= 1'b1;
            end
            if (tx_low) begin
                do_q <= tx_low_nib;
            end
            if (csb_rise) begin
                oe_q <= 1'b0;
            end
        end
    end

    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_first  = rx_first_q;
    assign bus.rx_end    = rx_end_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.tx_ready  = tx_ready_q;
    assign bus.qpi_io_do = do_q;
    assign bus.qpi_io_oe = oe_q;

`ifdef QPI_RESPONDER_ERR_EN
    logic err_q;
    logic tx_was_valid;

    // Sticky protocol error: partial byte, wrong edge polarity, or TX underrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q        <= 1'b0;
            tx_was_valid <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_was_valid <= bus.tx_valid;
            end
            if (csb_fall) begin
                err_q <= 1'b0;
            end else if ((csb_rise & framing & ~hi_phase) |
                         (fall_e & ~hi_phase) | (rise_e & hi_phase) |
                         (tx_low & ~tx_was_valid)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.qpi_err = err_q;
`else
    assign bus.qpi_err = 1'b0;
`endif

endmodule

// File: tb/tb_qpi_responder.sv
// tb_qpi_responder: directed bench driving one host waveform into two
// responders (SYNC_STAGES 2 and 3) and checking both against hand-computed values.
`timescale 1ns/1ps
module tb_qpi_responder;

`ifdef QPI_RESPONDER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       csb = 1'b1;
    logic       qclk = 1'b1;
    logic [3:0] di = '0;
    logic       rd_req = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  ph = 80;
    time last_rise = 0;

    logic [8:0] q2[$];
    logic [8:0] q3[$];
    int end2 = 0, end3 = 0, rdy2 = 0, rdy3 = 0, oe2 = 0, oe3 = 0, lat2 = 0, lat3 = 0;

    qpi_responder_if if2 ();
    qpi_responder_if if3 ();

    assign if2.qpi_csb = csb;   assign if3.qpi_csb = csb;
    assign if2.qpi_clk = qclk;  assign if3.qpi_clk = qclk;
    assign if2.qpi_io_di = di;  assign if3.qpi_io_di = di;
    assign if2.rd_req = rd_req; assign if3.rd_req = rd_req;
    assign if2.tx_data = tx_data;   assign if3.tx_data = tx_data;
    assign if2.tx_valid = tx_valid; assign if3.tx_valid = tx_valid;

    qpi_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut2 (
        .clock(clk), .reset(rst), .bus(if2.slave));
    qpi_responder #(.SYNC_STAGES(3), .IDLE_BYTE(8'hFF)) dut3 (
        .clock(clk), .reset(rst), .bus(if3.slave));

    always #5 clk = ~clk;

    // Record decoder-side activity away from the active edge.
    always @(negedge clk) begin
        if (if2.rx_valid) begin
            q2.push_back({if2.rx_first, if2.rx_data});
            lat2 = int'(($time - last_rise) / 10);
        end
        if (if3.rx_valid) begin
            q3.push_back({if3.rx_first, if3.rx_data});
            lat3 = int'(($time - last_rise) / 10);
        end
        if (if2.rx_end) end2++;
        if (if3.rx_end) end3++;
        if (if2.tx_ready) rdy2++;
        if (if3.tx_ready) rdy3++;
        if (if2.qpi_io_oe) oe2++;
        if (if3.qpi_io_oe) oe3++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic cs_start();
        @(negedge clk);
        csb = 1'b0;
        #(ph);
    endtask

    task automatic cs_end();
        csb = 1'b1;
        #(3 * ph);
    endtask

    // One byte on the wire; returns what the host samples at the end of each phase.
    task automatic xfer(input logic [7:0] b, output logic [7:0] s2, output logic [7:0] s3);
        qclk = 1'b0;
        di = b[7:4];
        #(ph - 1);
        s2[7:4] = if2.qpi_io_do;
        s3[7:4] = if3.qpi_io_do;
        #1;
        qclk = 1'b1;
        di = b[3:0];
        last_rise = $time;
        #(ph - 1);
        s2[3:0] = if2.qpi_io_do;
        s3[3:0] = if3.qpi_io_do;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({if2.qpi_io_oe, if2.qpi_io_do, if2.rx_valid, if2.rx_first, if2.rx_end,
             if2.tx_ready, if2.rx_data, if2.qpi_err} !== 19'd0 ||
            {if3.qpi_io_oe, if3.qpi_io_do, if3.rx_valid, if3.rx_first, if3.rx_end,
             if3.tx_ready, if3.rx_data, if3.qpi_err} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: dut2 oe=%b do=%h data=%h dut3 oe=%b do=%h data=%h, expected all 0",
                     if2.qpi_io_oe, if2.qpi_io_do, if2.rx_data, if3.qpi_io_oe, if3.qpi_io_do, if3.rx_data);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        int b2 = q2.size(), b3 = q3.size(), e2 = end2, e3 = end3, o2 = oe2, o3 = oe3;
        logic [8:0] exp_q [3] = '{9'h121, 9'h05A, 9'h0C3};
        logic [7:0] s2, s3;
        rd_req = 1'b0;
        cs_start();
        xfer(8'h21, s2, s3);
        xfer(8'h5A, s2, s3);
        xfer(8'hC3, s2, s3);
        cs_end();
        n_cmp++;
        if (q2.size() - b2 != 3 || q3.size() - b3 != 3) begin
            n_bad++;
            $display("FAIL write_count: dut2=%0d dut3=%0d, expected 3", q2.size() - b2, q3.size() - b3);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (q2[b2+i] !== exp_q[i] || q3[b3+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL write_byte%0d: dut2={first,data}=%h dut3=%h, expected %h",
                         i, q2[b2+i], q3[b3+i], exp_q[i]);
            end
        end
        n_cmp++;
        if (end2 - e2 != 1 || end3 - e3 != 1) begin
            n_bad++;
            $display("FAIL write_rx_end: dut2=%0d dut3=%0d pulses, expected 1", end2 - e2, end3 - e3);
        end
        n_cmp++;
        if (oe2 != o2 || oe3 != o3) begin
            n_bad++;
            $display("FAIL write_oe: dut2=%0d dut3=%0d cycles driven, expected 0", oe2 - o2, oe3 - o3);
        end
    endtask

    task automatic test_read();
        int b2 = q2.size(), b3 = q3.size(), r2 = rdy2, r3 = rdy3, e2 = end2, e3 = end3;
        logic [7:0] s2, s3;
        rd_req = 1'b1;
        tx_valid = 1'b0;
        cs_start();
        xfer(8'h20, s2, s3);
        xfer(8'h00, s2, s3);
        n_cmp++;
        if (if2.qpi_io_oe !== 1'b0 || if3.qpi_io_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL read_oe_turn: dut2=%b dut3=%b, expected 0", if2.qpi_io_oe, if3.qpi_io_oe);
        end
        tx_data = 8'h01;
        tx_valid = 1'b1;
        xfer(8'h00, s2, s3);
        n_cmp++;
        if (s2 !== 8'h01 || s3 !== 8'h01) begin
            n_bad++;
            $display("FAIL read_byte0: dut2=%h dut3=%h, expected 01", s2, s3);
        end
        tx_data = 8'h00;
        xfer(8'h00, s2, s3);
        tx_valid = 1'b0;
        n_cmp++;
        if (s2 !== 8'h00 || s3 !== 8'h00) begin
            n_bad++;
            $display("FAIL read_byte1: dut2=%h dut3=%h, expected 00", s2, s3);
        end
        n_cmp++;
        if (if2.qpi_io_oe !== 1'b1 || if3.qpi_io_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL read_oe_active: dut2=%b dut3=%b, expected 1", if2.qpi_io_oe, if3.qpi_io_oe);
        end
        cs_end();
        rd_req = 1'b0;
        n_cmp++;
        if (if2.qpi_io_oe !== 1'b0 || if3.qpi_io_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL read_oe_end: dut2=%b dut3=%b, expected 0", if2.qpi_io_oe, if3.qpi_io_oe);
        end
        n_cmp++;
        if (rdy2 - r2 != 2 || rdy3 - r3 != 2) begin
            n_bad++;
            $display("FAIL read_tx_ready: dut2=%0d dut3=%0d pulses, expected 2", rdy2 - r2, rdy3 - r3);
        end
        n_cmp++;
        if (q2.size() - b2 != 1 || q3.size() - b3 != 1 || q2[b2] !== 9'h120 || q3[b3] !== 9'h120 ||
            end2 - e2 != 1 || end3 - e3 != 1) begin
            n_bad++;
            $display("FAIL read_rx: dut2 n=%0d first=%h end=%0d dut3 n=%0d first=%h end=%0d, expected n=1 120 end=1",
                     q2.size() - b2, q2[b2], end2 - e2, q3.size() - b3, q3[b3], end3 - e3);
        end
    endtask

    task automatic test_underrun();
        int r2 = rdy2, r3 = rdy3;
        logic [7:0] s2, s3;
        rd_req = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h3C;
        cs_start();
        xfer(8'h20, s2, s3);
        xfer(8'h00, s2, s3);
        xfer(8'h00, s2, s3);
        cs_end();
        rd_req = 1'b0;
        n_cmp++;
        if (s2 !== 8'hFF || s3 !== 8'hFF) begin
            n_bad++;
            $display("FAIL underrun_byte: dut2=%h dut3=%h, expected ff", s2, s3);
        end
        n_cmp++;
        if (rdy2 != r2 || rdy3 != r3) begin
            n_bad++;
            $display("FAIL underrun_tx_ready: dut2=%0d dut3=%0d pulses, expected 0", rdy2 - r2, rdy3 - r3);
        end
        n_cmp++;
        if (if2.qpi_err !== ERR_EXP || if3.qpi_err !== ERR_EXP) begin
            n_bad++;
            $display("FAIL underrun_err: dut2=%b dut3=%b, expected %b", if2.qpi_err, if3.qpi_err, ERR_EXP);
        end
    endtask

    task automatic test_partial();
        int b2 = q2.size(), b3 = q3.size(), e2 = end2, e3 = end3;
        logic [7:0] s2, s3;
        cs_start();
        qclk = 1'b0;
        di = 4'hA;
        #(ph);
        csb = 1'b1;
        #(ph);
        qclk = 1'b1;
        #(2 * ph);
        n_cmp++;
        if (q2.size() != b2 || q3.size() != b3 || end2 - e2 != 1 || end3 - e3 != 1) begin
            n_bad++;
            $display("FAIL partial_frame: dut2 rx=%0d end=%0d dut3 rx=%0d end=%0d, expected rx=0 end=1",
                     q2.size() - b2, end2 - e2, q3.size() - b3, end3 - e3);
        end
        n_cmp++;
        if (if2.qpi_err !== ERR_EXP || if3.qpi_err !== ERR_EXP) begin
            n_bad++;
            $display("FAIL partial_err: dut2=%b dut3=%b, expected %b", if2.qpi_err, if3.qpi_err, ERR_EXP);
        end
        cs_start();
        xfer(8'h23, s2, s3);
        cs_end();
        n_cmp++;
        if (q2.size() - b2 != 1 || q3.size() - b3 != 1 || q2[b2] !== 9'h123 || q3[b3] !== 9'h123) begin
            n_bad++;
            $display("FAIL partial_next: dut2 n=%0d %h dut3 n=%0d %h, expected n=1 123",
                     q2.size() - b2, q2[b2], q3.size() - b3, q3[b3]);
        end
        n_cmp++;
        if (if2.qpi_err !== 1'b0 || if3.qpi_err !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_err_clear: dut2=%b dut3=%b, expected 0", if2.qpi_err, if3.qpi_err);
        end
    endtask

    task automatic test_reset_mid_read();
        int b2, b3, e2, e3;
        logic [8:0] exp_q [3] = '{9'h125, 9'h000, 9'h000};
        logic [7:0] s2, s3;
        rd_req = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        cs_start();
        xfer(8'h20, s2, s3);
        xfer(8'h00, s2, s3);
        qclk = 1'b0;
        #(ph);
        n_cmp++;
        if (if2.qpi_io_oe !== 1'b1 || if3.qpi_io_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL midrd_oe_before: dut2=%b dut3=%b, expected 1", if2.qpi_io_oe, if3.qpi_io_oe);
        end
        rst = 1'b1;
        #10;
        rst = 1'b0;
        b2 = q2.size(); b3 = q3.size(); e2 = end2; e3 = end3;
        n_cmp++;
        if (if2.qpi_io_oe !== 1'b0 || if3.qpi_io_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL midrd_oe_after: dut2=%b dut3=%b, expected 0", if2.qpi_io_oe, if3.qpi_io_oe);
        end
        qclk = 1'b1;
        #(ph);
        xfer(8'h77, s2, s3);
        cs_end();
        tx_valid = 1'b0;
        rd_req = 1'b0;
        n_cmp++;
        if (q2.size() != b2 || q3.size() != b3 || end2 != e2 || end3 != e3) begin
            n_bad++;
            $display("FAIL midrd_hold: dut2 rx=%0d end=%0d dut3 rx=%0d end=%0d, expected 0 0",
                     q2.size() - b2, end2 - e2, q3.size() - b3, end3 - e3);
        end
        cs_start();
        xfer(8'h25, s2, s3);
        xfer(8'h00, s2, s3);
        xfer(8'h00, s2, s3);
        cs_end();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (q2[b2+i] !== exp_q[i] || q3[b3+i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL midrd_write%0d: dut2=%h dut3=%h, expected %h", i, q2[b2+i], q3[b3+i], exp_q[i]);
            end
        end
        n_cmp++;
        if (q2.size() - b2 != 3 || q3.size() - b3 != 3 || end2 - e2 != 1 || end3 - e3 != 1) begin
            n_bad++;
            $display("FAIL midrd_write_count: dut2 rx=%0d end=%0d dut3 rx=%0d end=%0d, expected 3 1",
                     q2.size() - b2, end2 - e2, q3.size() - b3, end3 - e3);
        end
    endtask

    task automatic test_depth3();
        ph = 70;
        test_write();
        n_cmp++;
        if (lat2 != 4 || lat3 != 5) begin
            n_bad++;
            $display("FAIL depth_latency: dut2=%0d dut3=%0d cycles, expected 4 and 5", lat2, lat3);
        end
        test_read();
        ph = 80;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_underrun();
        test_partial();
        test_reset_mid_read();
        test_depth3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qpi_responder.md
# qpi_responder

Device-side QPI link layer for the accelerator. It oversamples the host's QPI pins in the `clock` domain, deserialises nibble pairs into command/data bytes for the command decoder, and serialises decoder-supplied response bytes back onto the bus after a one-byte turnaround. It sits between the top-level tristate pads and the command/memory-upload logic.

## Interface
- `SYNC_STAGES`, 2, synchroniser depth on `qpi_csb`, `qpi_clk` and `qpi_io_di`; legal values are 2 and 3.
- `IDLE_BYTE`, 8'hFF, byte driven during a read byte when no response byte is available.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `qpi_csb`  in  1  host chip select, active low, asynchronous to `clock`.
- `qpi_clk`  in  1  host QPI clock, asynchronous to `clock`.
- `qpi_io_di`  in  4  pad input nibble.
- `qpi_io_do`  out  4  pad output nibble.
- `qpi_io_oe`  out  1  pad output enable.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds a received byte. There is no backpressure.
- `rx_data`  out  8  received byte; high nibble first on the wire.
- `rx_first`  out  1  qualifies `rx_valid`: this is the first byte after `qpi_csb` fell (the command byte).
- `rx_end`  out  1  one-cycle pulse when the transaction ends (synchronised `qpi_csb` rises).
- `rd_req`  in  1  level: the decoder requests read direction; sampled at byte boundaries.
- `tx_data`  in  8  response byte.
- `tx_valid`  in  1  `tx_data` is available.
- `tx_ready`  out  1  one-cycle pulse: `tx_data` was consumed.
- `qpi_err`  out  1  sticky protocol error (see Configuration).

## Operation
- **Inputs.** All pins pass through `SYNC_STAGES` flops. Edges are detected on the synchronised `qpi_clk`. Data is taken from the synchronised `qpi_io_di` in the same cycle the edge is detected, because the host changes data together with the clock edge.
- **Clock gating by chip select.** Edges count only while synchronised `qpi_csb` is 0. The `qpi_clk` level at the `qpi_csb` fall is ignored.
- **Byte framing.**
  - A falling edge carries the high nibble; the following rising edge carries the low nibble and completes the byte.
  - The nibble phase resets to "high" on every `qpi_csb` fall.
- **FSM states:** IDLE, RX, TURN, TX, HOLD.
- **IDLE.** Synchronised `qpi_csb` falls → RX; `rx_first` is armed.
- **RX.**
  - Each completed byte pulses `rx_valid` for one cycle; `rx_first` is high only for byte 0.
  - If `rd_req` is 1 in the cycle of a byte completion → TURN.
- **TURN.** The next byte period is a dummy: nothing is driven, no `rx_valid`. Its rising edge → TX.
- **TX.**
  - On each falling edge, latch `tx_data` if `tx_valid`, otherwise latch `IDLE_BYTE`. Pulse `tx_ready` only when `tx_valid` was consumed.
  - Drive the high nibble from the falling edge and the low nibble from the rising edge.
  - `qpi_io_oe` goes to 1 at the first TX falling edge and stays 1 until `qpi_csb` rises.
- **End of transaction.** Synchronised `qpi_csb` rising, from any state → IDLE: `qpi_io_oe` = 0, `rx_end` pulses once, and any partial byte is dropped (no `rx_valid`).
- **HOLD.** Entered after reset if synchronised `qpi_csb` is 0. All edges are ignored until `qpi_csb` rises, which returns to IDLE. `rx_end` is not pulsed for the aborted transaction.
- **Simultaneous events.** A `qpi_csb` rise detected in the same cycle as a `qpi_clk` edge wins: the edge is discarded.

## Timing
- **Reset values:** `qpi_io_oe` = 0, `qpi_io_do` = 0, `rx_valid`/`rx_first`/`rx_end`/`tx_ready` = 0, `rx_data` = 0, `qpi_err` = 0; state IDLE (or HOLD, see Operation).
- **Edge detection:** an edge is detected `SYNC_STAGES`+1 cycles after the pin edge.
- **Receive latency:** `rx_valid` is asserted the cycle after detection of the completing rising edge.
- **Transmit latency:** `qpi_io_do` is updated the cycle after edge detection, i.e. at most `SYNC_STAGES`+2 cycles after the pin edge.
- **Host requirement:** each `qpi_clk` phase lasts at least `SYNC_STAGES`+4 `clock` periods, and the host samples at the end of the phase. With a 10 ns clock and the default depth, a 17 ns phase sampled at 15 ns is too short; the host must use at least 60 ns per phase.
- **`rd_req` window:** `rd_req` must be stable by the cycle `rx_valid` is asserted for the command byte, or the turnaround is delayed by one byte.
- **`tx_data` setup:** `tx_data`/`tx_valid` are sampled in the falling-edge detection cycle.

## Configuration
- **`QPI_RESPONDER_ERR_EN` defined:** `qpi_err` is set when any of the following occurs:
  - `qpi_csb` rises after a high nibble without its low nibble;
  - a `qpi_clk` edge of the wrong polarity arrives for the current nibble phase;
  - a TX byte completes while `tx_valid` was 0.

  `qpi_err` clears on the next `qpi_csb` fall or on `reset`.
- **`QPI_RESPONDER_ERR_EN` undefined:** `qpi_err` is constant 0 and no error logic is synthesised. All other behaviour is identical.

## Test plan
- **Write:** after `reset`, the host sends 0x21, 0x5A, 0xC3 at 80 ns per phase → three `rx_valid` pulses with data 0x21, 0x5A, 0xC3, `rx_first` only on 0x21, then one `rx_end` pulse; `qpi_io_oe` stays 0.
- **Read:** command 0x20 with `rd_req` high, one dummy byte, then two read bytes, with the decoder offering 0x01 then 0x00 → host samples 0x01, 0x00; two `tx_ready` pulses; `qpi_io_oe` is 1 from the first read falling edge until `qpi_csb` rises.
- **Read underrun:** a read byte with `tx_valid` = 0 → host samples 0xFF, no `tx_ready`; `qpi_err` = 1 with `QPI_RESPONDER_ERR_EN`, 0 without.
- **Partial byte:** `qpi_csb` rises after only the high nibble 0xA → no `rx_valid`, one `rx_end`; `qpi_err` = 1 with the macro. The next transaction 0x23 is received correctly and clears `qpi_err`.
- **Reset mid-read:** `reset` pulsed during TX → `qpi_io_oe` = 0 the next cycle, no `rx_valid` until `qpi_csb` has risen. A following 0x25, 0x00, 0x00 write is received intact.
- **Depth 3:** `SYNC_STAGES` = 3 with the minimum legal phase (7 clocks) → write and read scenarios still pass; `rx_valid` is asserted exactly 5 cycles after the completing pin edge.
